serial_sub32: RTL
=================

Name: serial_sub32

Overview:
- Multi-cycle, chunk-serial subtractor. Computes D = A1 - A2 - bin with borrow-out B.
- Companion to the combinational 32-bit ripple-carry adder: same operand/width conventions, opposite arithmetic direction, sequential datapath.
- Processes CHUNK bits per clock behind a start/busy/done handshake, trading latency for a narrow CHUNK-bit subtract slice.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits subtracted per clock; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when idle (busy=0)
- A1  input  WIDTH  minuend; latched when start is accepted
- A2  input  WIDTH  subtrahend; latched when start is accepted
- bin  input  1  borrow-in; latched when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; D and B are valid from this cycle
- D  output  WIDTH  difference, modulo 2^WIDTH
- B  output  1  borrow-out; 1 iff A1 < A2 + bin (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst at a clock edge: state=IDLE, busy=0, done=0, D=0, B=0, chunk counter=0, internal operand registers=0. rst overrides start and any in-flight operation; no result is produced for an aborted operation.
- IDLE state:
  - If start=1 at edge k: latch A1, A2, bin; set running borrow := bin; counter := 0; go to RUN. busy=1 from edge k.
  - If start=0: stay in IDLE.
- RUN state, per edge:
  - Slice i (counter value) computes A1[i*CHUNK +: CHUNK] - A2[i*CHUNK +: CHUNK] - borrow.
  - Write the CHUNK-bit difference into the result shift register; update borrow; counter += 1.
  - On the last slice (counter = N-1): load D from the completed result and B from the final borrow; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge k, so D, B and done are visible after edge k+N (N=8 by default). busy is high for N cycles.
- Start while busy: ignored, not queued.
- Operand inputs may change freely during RUN without effect on the result.
- Back-to-back: start in the same cycle done=1 is accepted (FSM is already IDLE). Throughput is one operation per N cycles.
- D and B hold their last value until the next done or rst. They do not change during RUN.
- Counter wraps implicitly; it is reset to 0 on every accepted start.
- Arithmetic: two's-complement subtract. Each slice is implemented as a + ~b + ~borrow, with borrow_out = ~carry_out.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port V (1 bit). V is the signed overflow of A1 - A2 - bin: operand signs differ and the sign of D differs from the sign of A1.
  - V is updated alongside D and B at done. V is 0 on reset and holds between operations.
- Undefined: port V is absent; no extra logic.

Decomposition:
- Package serial_sub_pkg holds:
  - WIDTH and CHUNK defaults;
  - derived N and counter width $clog2(N);
  - state enum {IDLE, RUN}, 1-bit encoding.
- One sub-module, chunk_sub: a combinational CHUNK-bit subtract slice.
  - Inputs: a, b, bin. Outputs: d, bout.
  - Instantiated once and reused every cycle on the selected slice.
- The top level holds the FSM, counter, operand/result shift registers and output registers.

Test Plan:
- A1=5, A2=3, bin=0, one-cycle start -> after 8 cycles done=1, D=0x00000002, B=0; busy high for exactly 8 cycles.
- A1=0, A2=1, bin=0 -> D=0xFFFFFFFF, B=1 (with SERIAL_SUB_OVF_EN: V=0).
- A1=0x80000000, A2=1, bin=0 -> D=0x7FFFFFFF, B=0, V=1 when SERIAL_SUB_OVF_EN is defined.
- A1=A2=0x12345678, bin=1 -> D=0xFFFFFFFF, B=1. Then change A1 to 0 mid-RUN and pulse start at cycle 3 -> result unchanged, second start ignored.
- Start op with A1=0xDEADBEEF, A2=0x1; assert rst at cycle 4 -> next cycle busy=0, done=0, D=0, B=0, no done pulse follows. New start with A1=10, A2=4 -> D=6 after 8 cycles.
- Back-to-back: second start (A1=100, A2=1) asserted in the done cycle of 5-3 -> second done exactly 8 cycles later with D=99.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants and state encoding for the chunk-serial subtractor serial_sub32.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;
    localparam int N_CHUNKS  = DEF_WIDTH / DEF_CHUNK;
    localparam int CNT_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_sub32_chunk_sub.sv
// Combinational CHUNK-bit subtract slice: d = a - b - bin, built as a + ~b + ~bin.
module chunk_sub #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] carry;

    // Carry-in of the inverted-subtrahend add is the complement of the borrow-in.
    assign carry[0] = ~bin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_bit
            logic nb;
            assign nb            = ~b[gi];
            assign d[gi]         = a[gi] ^ nb ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & nb) | (carry[gi] & (a[gi] ^ nb));
        end
    endgenerate

    assign bout = ~carry[CHUNK];

endmodule

// File: rtl/serial_sub32.sv
// Chunk-serial subtractor: D = A1 - A2 - bin over WIDTH/CHUNK clocks with start/busy/done.
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub32
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int NC = WIDTH / CHUNK;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] d_reg;
    logic             b_out_reg;

    logic [CHUNK-1:0] slice_d;
    logic             slice_bout;
    logic [WIDTH-1:0] res_next;
    logic             last_slice;

    // Operands shift right so the active slice is always the low CHUNK bits.
    chunk_sub #(.CHUNK(CHUNK)) u_slice (
        .a    (a_reg[CHUNK-1:0]),
        .b    (b_reg[CHUNK-1:0]),
        .bin  (borrow_reg),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Result fills from the top; after NC shifts slice 0 has reached bit 0.
    assign res_next   = {slice_d, res_reg[WIDTH-1:CHUNK]};
    assign last_slice = (cnt_reg == CW'(NC - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic a_sign_reg;
    logic b_sign_reg;
    logic v_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sign_reg <= 1'b0;
            b_sign_reg <= 1'b0;
            v_reg      <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            a_sign_reg <= A1[WIDTH-1];
            b_sign_reg <= A2[WIDTH-1];
        end else if (state_reg == RUN && last_slice) begin
            v_reg <= (a_sign_reg ^ b_sign_reg) & (res_next[WIDTH-1] ^ a_sign_reg);
        end
    end

    assign V = v_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            d_reg      <= '0;
            b_out_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= A1;
                        b_reg      <= A2;
                        borrow_reg <= bin;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    a_reg      <= a_reg >> CHUNK;
                    b_reg      <= b_reg >> CHUNK;
                    res_reg    <= res_next;
                    borrow_reg <= slice_bout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_slice) begin
                        d_reg     <= res_next;
                        b_out_reg <= slice_bout;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign D    = d_reg;
    assign B    = b_out_reg;

endmodule
